rv32im_decode_stage: RTL and testbench

RV32IM_DECODE_STAGE -- requirements
Module: rv32im_decode_stage

---
 rtl/rv32im_decode_stage.sv | 200 ++++++++++++++++++++
 tb/tb_rv32im_decode_stage.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/rv32im_decode_stage.sv
// rv32im_decode_stage: RV32IM decoder feeding a BUF_DEPTH-entry output FIFO with valid/ready handshakes
module rv32im_decode_stage #(
  parameter int PC_WIDTH  = 32,
  parameter int M_EXT     = 1,
  parameter int BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [31:0]         i_inst,
  input  logic [PC_WIDTH-1:0] i_pc,
  input  logic                i_flush,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [4:0]          o_rs1_addr,
  output logic [4:0]          o_rs2_addr,
  output logic [4:0]          o_rd_addr,
  output logic [31:0]         o_imm,
  output logic [10:0]         o_opcode,
  output logic [13:0]         o_alu_op,
  output logic [7:0]          o_mul_op,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic                o_illegal
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  typedef struct packed {
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [31:0]         imm;
    logic [10:0]         opcode;
    logic [13:0]         alu_op;
    logic [7:0]          mul_op;
    logic [PC_WIDTH-1:0] pc;
    logic                illegal;
  } entry_t;
  function automatic logic [13:0] alu_sel(input logic [2:0] f, input logic alt);
    logic [3:0] i;
    case (f)
      3'b000:  i = alt ? 4'd1 : 4'd0;
      3'b001:  i = 4'd7;
      3'b010:  i = 4'd2;
      3'b011:  i = 4'd3;
      3'b100:  i = 4'd4;
      3'b101:  i = alt ? 4'd9 : 4'd8;
      3'b110:  i = 4'd5;
      default: i = 4'd6;
    endcase
    return 14'd1 << i;
  endfunction
  function automatic logic [13:0] br_sel(input logic [2:0] f);
    logic [3:0] i;
    case (f)
      3'b000:  i = 4'd10;
      3'b001:  i = 4'd11;
      3'b100:  i = 4'd2;
      3'b101:  i = 4'd12;
      3'b110:  i = 4'd3;
      default: i = 4'd13;
    endcase
    return 14'd1 << i;
  endfunction
  logic [6:0]  op, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_z;
  logic [10:0] opc;
  logic [13:0] alu;
  logic [7:0]  mul;
  logic        ill;
  entry_t      d, h;
  assign op    = i_inst[6:0];
  assign f3    = i_inst[14:12];
  assign f7    = i_inst[31:25];
  assign imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
  assign imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign imm_b = {{20{i_inst[31]}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign imm_j = {{12{i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
  assign imm_u = {i_inst[31:12], 12'h000};
  assign imm_z = {20'h0, i_inst[31:20]};
  always_comb begin
    d     = '0;
    opc   = '0;
    alu   = '0;
    mul   = '0;
    ill   = 1'b0;
    d.rs1 = i_inst[19:15];
    d.rs2 = i_inst[24:20];
    d.rd  = i_inst[11:7];
    d.pc  = i_pc;
    case (op)
      7'b0110011: begin
        opc[0] = 1'b1;
        if (f7 == 7'b0000001) begin
          mul[f3] = 1'b1;
          ill     = (M_EXT == 0);
        end else begin
          alu = alu_sel(f3, f7[5]);
          ill = !(f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
        end
      end
      7'b0010011: begin
        opc[1] = 1'b1;
        d.imm  = imm_i;
        alu    = alu_sel(f3, f3 == 3'b101 && f7[5]);
        ill    = (f3 == 3'b001 && f7 != 7'b0) || (f3 == 3'b101 && f7 != 7'b0 && f7 != 7'b0100000);
      end
      7'b0000011: begin
        opc[2] = 1'b1;
        d.imm  = imm_i;
        alu[0] = 1'b1;
        ill    = f3 == 3'b011 || f3[2:1] == 2'b11;
      end
      7'b0100011: begin
        opc[3] = 1'b1;
        d.imm  = imm_s;
        alu[0] = 1'b1;
        ill    = f3 > 3'b010;
      end
      7'b1100011: begin
        opc[4] = 1'b1;
        d.imm  = imm_b;
        alu    = br_sel(f3);
        ill    = f3[2:1] == 2'b01;
      end
      7'b1101111: begin
        opc[5] = 1'b1;
        d.imm  = imm_j;
        alu[0] = 1'b1;
      end
      7'b1100111: begin
        opc[6] = 1'b1;
        d.imm  = imm_i;
        alu[0] = 1'b1;
        ill    = f3 != 3'b000;
      end
      7'b0110111: begin
        opc[7] = 1'b1;
        d.imm  = imm_u;
        alu[0] = 1'b1;
      end
      7'b0010111: begin
        opc[8] = 1'b1;
        d.imm  = imm_u;
        alu[0] = 1'b1;
      end
      7'b1110011: begin
        opc[9] = 1'b1;
        d.imm  = imm_z;
      end
      7'b0001111: begin
        opc[10] = 1'b1;
        d.imm   = imm_z;
      end
      default: ill = 1'b1;
    endcase
    d.illegal = ill;
    d.opcode  = ill ? '0 : opc;
    d.alu_op  = ill ? '0 : alu;
    d.mul_op  = ill ? '0 : mul;
  end
  entry_t         mem [BUF_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           push, pop;
  assign o_ready = count < CW'(BUF_DEPTH);
  assign o_valid = count != '0;
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < BUF_DEPTH; k++) mem[k] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= d;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign h          = mem[rd_ptr];
  assign o_rs1_addr = h.rs1;
  assign o_rs2_addr = h.rs2;
  assign o_rd_addr  = h.rd;
  assign o_imm      = h.imm;
  assign o_opcode   = h.opcode;
  assign o_alu_op   = h.alu_op;
  assign o_mul_op   = h.mul_op;
  assign o_pc       = h.pc;
  assign o_illegal  = h.illegal;
endmodule

// File: tb/tb_rv32im_decode_stage.sv
// tb_rv32im_decode_stage: directed vectors against rv32im_decode_stage with M_EXT=1 and M_EXT=0 instances
module tb_rv32im_decode_stage;
  logic        clk = 1'b0;
  logic        rst_n, i_valid, i_flush, i_ready;
  logic [31:0] i_inst, i_pc;
  logic        o_ready, o_valid, o_illegal;
  logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
  logic [31:0] o_imm, o_pc;
  logic [10:0] o_opcode;
  logic [13:0] o_alu_op;
  logic [7:0]  o_mul_op;
  logic        z_ready, z_valid, z_illegal;
  logic [4:0]  z_rs1, z_rs2, z_rd;
  logic [31:0] z_imm, z_pc;
  logic [10:0] z_opcode;
  logic [13:0] z_alu_op;
  logic [7:0]  z_mul_op;
  int          n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  rv32im_decode_stage #(.PC_WIDTH(32), .M_EXT(1), .BUF_DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_inst(i_inst), .i_pc(i_pc),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready), .o_rs1_addr(o_rs1_addr),
    .o_rs2_addr(o_rs2_addr), .o_rd_addr(o_rd_addr), .o_imm(o_imm), .o_opcode(o_opcode),
    .o_alu_op(o_alu_op), .o_mul_op(o_mul_op), .o_pc(o_pc), .o_illegal(o_illegal));
  rv32im_decode_stage #(.PC_WIDTH(32), .M_EXT(0), .BUF_DEPTH(2)) u_dut_nom (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(z_ready), .i_inst(i_inst), .i_pc(i_pc),
    .i_flush(i_flush), .o_valid(z_valid), .i_ready(i_ready), .o_rs1_addr(z_rs1),
    .o_rs2_addr(z_rs2), .o_rd_addr(z_rd), .o_imm(z_imm), .o_opcode(z_opcode),
    .o_alu_op(z_alu_op), .o_mul_op(z_mul_op), .o_pc(z_pc), .o_illegal(z_illegal));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    i_valid = 1'b1;
    i_inst  = inst;
    i_pc    = pc;
    i_ready = 1'b1;
    step();
    i_valid = 1'b0;
  endtask
  task automatic chk_dec(input string t, input logic [10:0] opc, input logic [13:0] alu,
                         input logic [7:0] mul, input logic [31:0] imm, input logic ill);
    chk({t, ".valid"}, 32'(o_valid), 32'd1);
    chk({t, ".opcode"}, 32'(o_opcode), 32'(opc));
    chk({t, ".alu"}, 32'(o_alu_op), 32'(alu));
    chk({t, ".mul"}, 32'(o_mul_op), 32'(mul));
    chk({t, ".imm"}, o_imm, imm);
    chk({t, ".illegal"}, 32'(o_illegal), 32'(ill));
  endtask
  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0; i_inst = '0; i_pc = '0;
    #12;
    chk("rst.valid", 32'(o_valid), 32'd0);
    chk("rst.ready", 32'(o_ready), 32'd1);
    chk("rst.imm", o_imm, 32'd0);
    chk("rst.opcode", 32'(o_opcode), 32'd0);
    rst_n = 1'b1;
    step();
    send(32'h002081B3, 32'h40);
    chk_dec("add", 11'h001, 14'h0001, 8'h00, 32'h0, 1'b0);
    chk("add.rd", 32'(o_rd_addr), 32'd3);
    chk("add.rs1", 32'(o_rs1_addr), 32'd1);
    chk("add.rs2", 32'(o_rs2_addr), 32'd2);
    chk("add.pc", o_pc, 32'h40);
    send(32'h027302B3, 32'h44);
    chk_dec("mul", 11'h001, 14'h0000, 8'h01, 32'h0, 1'b0);
    chk("mul_nom.illegal", 32'(z_illegal), 32'd1);
    chk("mul_nom.opcode", 32'(z_opcode), 32'd0);
    chk("mul_nom.alu", 32'(z_alu_op), 32'd0);
    chk("mul_nom.mul", 32'(z_mul_op), 32'd0);
    send(32'hFE208EE3, 32'h100);
    chk_dec("beq", 11'h010, 14'h0400, 8'h00, 32'hFFFFFFFC, 1'b0);
    chk("beq.pc", o_pc, 32'h100);
    send(32'h403100B3, 32'h104);
    chk_dec("sub", 11'h001, 14'h0002, 8'h00, 32'h0, 1'b0);
    send(32'h403110B3, 32'h108);
    chk_dec("bad_f7", 11'h000, 14'h0000, 8'h00, 32'h0, 1'b1);
    chk("bad_f7.pc", o_pc, 32'h108);
    send(32'hFFF00093, 32'h10C);
    chk_dec("addi", 11'h002, 14'h0001, 8'h00, 32'hFFFFFFFF, 1'b0);
    send(32'h40315093, 32'h110);
    chk_dec("srai", 11'h002, 14'h0200, 8'h00, 32'h00000403, 1'b0);
    send(32'h0020A423, 32'h114);
    chk_dec("sw", 11'h008, 14'h0001, 8'h00, 32'h8, 1'b0);
    send(32'h123452B7, 32'h118);
    chk_dec("lui", 11'h080, 14'h0001, 8'h00, 32'h12345000, 1'b0);
    send(32'hFF9FF06F, 32'h11C);
    chk_dec("jal", 11'h020, 14'h0001, 8'h00, 32'hFFFFFFF8, 1'b0);
    send(32'h0020A063, 32'h120);
    chk_dec("br_f3_010", 11'h000, 14'h0000, 8'h00, 32'h0, 1'b1);
    send(32'hFFFFFFFF, 32'h124);
    chk_dec("bad_op", 11'h000, 14'h0000, 8'h00, 32'h0, 1'b1);
    send(32'hC0002073, 32'h128);
    chk_dec("csrrs", 11'h200, 14'h0000, 8'h00, 32'h00000C00, 1'b0);
    send(32'h023150B3, 32'h12C);
    chk_dec("divu", 11'h001, 14'h0000, 8'h20, 32'h0, 1'b0);
    step();
    chk("drain.valid", 32'(o_valid), 32'd0);
    i_ready = 1'b0; i_valid = 1'b1; i_inst = 32'h002081B3;
    i_pc = 32'h200; step();
    chk("fifo1.ready", 32'(o_ready), 32'd1);
    i_pc = 32'h204; step();
    chk("fifo2.ready", 32'(o_ready), 32'd0);
    i_pc = 32'h208; step();
    chk("fifo3.ready", 32'(o_ready), 32'd0);
    chk("fifo3.head", o_pc, 32'h200);
    i_ready = 1'b1; step();
    chk("pop1.ready", 32'(o_ready), 32'd1);
    chk("pop1.head", o_pc, 32'h204);
    step();
    i_valid = 1'b0;
    chk("pop2.head", o_pc, 32'h208);
    chk("pop2.valid", 32'(o_valid), 32'd1);
    step();
    chk("pop3.valid", 32'(o_valid), 32'd0);
    i_ready = 1'b0; i_valid = 1'b1; i_pc = 32'h300;
    step(); step();
    chk("fl.full", 32'(o_ready), 32'd0);
    i_flush = 1'b1; step();
    i_flush = 1'b0; i_valid = 1'b0;
    chk("fl.valid", 32'(o_valid), 32'd0);
    chk("fl.ready", 32'(o_ready), 32'd1);
    i_ready = 1'b1; step();
    chk("fl.after", 32'(o_valid), 32'd0);
    send(32'h123452B7, 32'h400);
    chk("rst_mid.pre", 32'(o_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.valid", 32'(o_valid), 32'd0);
    chk("rst_mid.imm", o_imm, 32'd0);
    chk("rst_mid.pc", o_pc, 32'd0);
    chk("rst_mid.rd", 32'(o_rd_addr), 32'd0);
    chk("rst_mid.ready", 32'(o_ready), 32'd1);
    #2 rst_n = 1'b1;
    send(32'h002081B3, 32'h404);
    chk("post_rst.valid", 32'(o_valid), 32'd1);
    chk("post_rst.rd", 32'(o_rd_addr), 32'd3);
    chk("post_rst.pc", o_pc, 32'h404);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
